// File: rtl/dvp_roi_packer.sv
// Crops a fixed region of interest out of the captured RGB565 pixel stream,
// packs pixel pairs into 32-bit words and buffers them in a first-word-fall-through FIFO.
module dvp_roi_packer #(
    parameter int H_START    = 0,
    parameter int H_SIZE     = 640,
    parameter int V_START    = 0,
    parameter int V_SIZE     = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        PCLK,
    input  logic        Rst_n,
    input  logic        DataValid,
    input  logic [15:0] DataPixel,
    input  logic        DataHs,
    input  logic        DataVs,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutData,
    output logic        OutSof,
    output logic        OutEol,
    output logic        Overflow,
    output logic        FrameDone
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [31:0] H_LO    = 32'(H_START);
    localparam logic [31:0] H_HI    = 32'(H_START + H_SIZE);
    localparam logic [31:0] V_LO    = 32'(V_START);
    localparam logic [31:0] V_HI    = 32'(V_START + V_SIZE);
    localparam logic [31:0] DEPTH_U = 32'(FIFO_DEPTH);

    if ((H_START % 2) != 0 || (H_SIZE % 2) != 0 || H_SIZE < 2 || V_SIZE < 1 ||
        H_START < 0 || V_START < 0 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("dvp_roi_packer: illegal parameter set");
    end

    logic            vsPrev_q, hsPrev_q;
    logic            armed_q, armed_d;
    logic            sofPending_q, sofPending_d;
    logic [11:0]     col_q, col_d;
    logic [11:0]     row_q, row_d;
    logic [15:0]     half_q, half_d;
    logic            halfValid_q, halfValid_d;
    logic            stageValid_q, stageValid_d;
    logic [31:0]     stageData_q, stageData_d;
    logic            stageEol_q, stageEol_d;
    logic            stageLast_q, stageLast_d;
    logic [AW-1:0]   wrPtr_q, wrPtr_d;
    logic [AW-1:0]   rdPtr_q, rdPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [33:0]     mem [FIFO_DEPTH];

    logic            vsRise, hsFall, inRoi, isEol, isLastRow;
    logic            pop, pushOk, push, drop;
    logic [31:0]     colW, rowW;
    logic [33:0]     rdWord;

    assign colW      = 32'(col_q);
    assign rowW      = 32'(row_q);
    assign vsRise    = DataVs && !vsPrev_q;
    assign hsFall    = !DataHs && hsPrev_q;
    assign inRoi     = (colW >= H_LO) && (colW < H_HI) && (rowW >= V_LO) && (rowW < V_HI);
    assign isEol     = (colW == H_HI - 32'd1);
    assign isLastRow = (rowW == V_HI - 32'd1);

    assign pop    = OutValid && OutReady;
    assign pushOk = (32'(count_q) < DEPTH_U) || pop;
    assign push   = stageValid_q && pushOk;
    assign drop   = stageValid_q && !pushOk;

    always_comb begin
        armed_d      = armed_q;
        sofPending_d = sofPending_q;
        col_d        = col_q;
        row_d        = row_q;
        half_d       = half_q;
        halfValid_d  = halfValid_q;
        stageValid_d = 1'b0;
        stageData_d  = stageData_q;
        stageEol_d   = stageEol_q;
        stageLast_d  = stageLast_q;
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;

        if (push) begin
            wrPtr_d      = wrPtr_q + AW'(1);
            sofPending_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A frame start outranks a line end, which outranks pixel data.
        if (vsRise) begin
            armed_d      = 1'b1;
            sofPending_d = 1'b1;
            col_d        = '0;
            row_d        = '0;
            halfValid_d  = 1'b0;
        end else if (hsFall) begin
            if (col_q != '0 && row_q != 12'hFFF) begin
                row_d = row_q + 12'd1;
            end
            col_d       = '0;
            halfValid_d = 1'b0;
        end else if (DataValid && armed_q) begin
            if (inRoi) begin
                if (!col_q[0]) begin
                    half_d      = DataPixel;
                    halfValid_d = 1'b1;
                end else if (halfValid_q) begin
                    stageValid_d = 1'b1;
                    stageData_d  = {DataPixel, half_q};
                    stageEol_d   = isEol;
                    stageLast_d  = isEol && isLastRow;
                    halfValid_d  = 1'b0;
                end
            end
            col_d = col_q + 12'd1;
        end
    end

    always_ff @(posedge PCLK or negedge Rst_n) begin
        if (!Rst_n) begin
            vsPrev_q     <= 1'b0;
            hsPrev_q     <= 1'b0;
            armed_q      <= 1'b0;
            sofPending_q <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            half_q       <= '0;
            halfValid_q  <= 1'b0;
            stageValid_q <= 1'b0;
            stageData_q  <= '0;
            stageEol_q   <= 1'b0;
            stageLast_q  <= 1'b0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            vsPrev_q     <= DataVs;
            hsPrev_q     <= DataHs;
            armed_q      <= armed_d;
            sofPending_q <= sofPending_d;
            col_q        <= col_d;
            row_q        <= row_d;
            half_q       <= half_d;
            halfValid_q  <= halfValid_d;
            stageValid_q <= stageValid_d;
            stageData_q  <= stageData_d;
            stageEol_q   <= stageEol_d;
            stageLast_q  <= stageLast_d;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
        end
    end

    // The sof flag is taken at push time so a dropped frame-start word hands it on.
    always_ff @(posedge PCLK) begin
        if (push) begin
            mem[wrPtr_q] <= {sofPending_q, stageEol_q, stageData_q};
        end
    end

    assign rdWord    = mem[rdPtr_q];
    assign OutValid  = (count_q != '0);
    assign OutData   = OutValid ? rdWord[31:0] : 32'd0;
    assign OutEol    = OutValid && rdWord[32];
    assign OutSof    = OutValid && rdWord[33];
    assign Overflow  = overflow_q;
    assign FrameDone = stageValid_q && stageLast_q;

endmodule
